// File: rtl/axi_adc_jesd204_pn_seq.sv
// axi_adc_jesd204_pn_seq: sweeps ADC channels one at a time through a PN settle/check window
// Ports:
//   up_clk, up_rstn           clock, asynchronous active-low reset
//   start, abort              begin a sweep (IDLE only) / terminate a running sweep
//   channel_mask              channels to test, sampled at start
//   test_pnseq_sel            PN select for the channel under test, sampled at start
//   idle_pnseq_sel            PN select for every channel not under test
//   up_adc_pn_oos/err         per-channel PN status
//   up_adc_pnseq_sel          per-channel PN select, channel i at [4i+3:4i]
//   busy, done, aborted       sweep running / success pulse / abort pulse
//   pass, cur_channel         per-channel result / channel under test (0 when idle)
module axi_adc_jesd204_pn_seq #(
    parameter int NUM_CHANNELS  = 4,
    parameter int SETTLE_CYCLES = 1024,
    parameter int CHECK_CYCLES  = 4096
) (
    input  logic                      up_clk,
    input  logic                      up_rstn,
    input  logic                      start,
    input  logic                      abort,
    input  logic [NUM_CHANNELS-1:0]   channel_mask,
    input  logic [3:0]                test_pnseq_sel,
    input  logic [3:0]                idle_pnseq_sel,
    input  logic [NUM_CHANNELS-1:0]   up_adc_pn_oos,
    input  logic [NUM_CHANNELS-1:0]   up_adc_pn_err,
    output logic [4*NUM_CHANNELS-1:0] up_adc_pnseq_sel,
    output logic                      busy,
    output logic                      done,
    output logic                      aborted,
    output logic [NUM_CHANNELS-1:0]   pass,
    output logic [3:0]                cur_channel
);
    localparam int MAXC = (SETTLE_CYCLES > CHECK_CYCLES) ? SETTLE_CYCLES : CHECK_CYCLES;
    localparam int CW   = $clog2(MAXC) + 1;
    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_CHECK, S_DONE} state_t;
    state_t                  r_state, w_state;
    logic [CW-1:0]           r_cnt, w_cnt;
    logic [NUM_CHANNELS-1:0] r_mask, w_mask, r_pass, w_pass;
    logic [3:0]              r_sel, w_sel, r_cur, w_cur, w_first, w_next;
    logic                    r_fail, w_fail, r_aborted, w_aborted, w_has_next, w_bad, w_fail_now, w_busy;
    assign w_busy      = (r_state == S_SETTLE) || (r_state == S_CHECK);
    assign busy        = w_busy;
    assign done        = (r_state == S_DONE);
    assign aborted     = r_aborted;
    assign pass        = r_pass;
    assign cur_channel = r_cur;
    // Lowest enabled channel at start, next enabled channel above the current one, and status of the current one
    always_comb begin
        w_first    = '0;
        w_next     = '0;
        w_has_next = 1'b0;
        w_bad      = 1'b0;
        for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
            if (channel_mask[i]) w_first = 4'(i);
            if (r_mask[i] && 4'(i) > r_cur) begin
                w_next     = 4'(i);
                w_has_next = 1'b1;
            end
            if (4'(i) == r_cur) w_bad = up_adc_pn_oos[i] | up_adc_pn_err[i];
        end
    end
    assign w_fail_now = r_fail | w_bad;
    always_comb begin
        up_adc_pnseq_sel = {NUM_CHANNELS{idle_pnseq_sel}};
        for (int i = 0; i < NUM_CHANNELS; i++)
            if (w_busy && r_cur == 4'(i)) up_adc_pnseq_sel[4*i +: 4] = r_sel;
    end
    always_comb begin
        w_state   = r_state;
        w_cnt     = r_cnt;
        w_mask    = r_mask;
        w_sel     = r_sel;
        w_pass    = r_pass;
        w_fail    = r_fail;
        w_cur     = r_cur;
        w_aborted = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_pass  = '0;
                    w_cnt   = '0;
                    w_state = (|channel_mask) ? S_SETTLE : S_DONE;
                    if (|channel_mask) begin
                        w_mask = channel_mask;
                        w_sel  = test_pnseq_sel;
                        w_cur  = w_first;
                    end
                end
            end
            S_SETTLE, S_CHECK: begin
                // abort outranks everything, including the result write of a final check cycle
                if (abort) begin
                    w_state   = S_IDLE;
                    w_cnt     = '0;
                    w_cur     = '0;
                    w_aborted = 1'b1;
                end else if (r_state == S_SETTLE) begin
                    w_cnt  = (r_cnt == CW'(SETTLE_CYCLES - 1)) ? '0 : r_cnt + 1'b1;
                    w_fail = 1'b0;
                    if (r_cnt == CW'(SETTLE_CYCLES - 1)) w_state = S_CHECK;
                end else if (r_cnt == CW'(CHECK_CYCLES - 1)) begin
                    for (int i = 0; i < NUM_CHANNELS; i++)
                        if (4'(i) == r_cur) w_pass[i] = ~w_fail_now;
                    w_cnt   = '0;
                    w_fail  = 1'b0;
                    w_cur   = w_has_next ? w_next : 4'd0;
                    w_state = w_has_next ? S_SETTLE : S_DONE;
                end else begin
                    w_cnt  = r_cnt + 1'b1;
                    w_fail = w_fail_now;
                end
            end
            default: w_state = S_IDLE;
        endcase
    end
    always_ff @(posedge up_clk or negedge up_rstn) begin
        if (!up_rstn) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_mask    <= '0;
            r_sel     <= '0;
            r_pass    <= '0;
            r_fail    <= 1'b0;
            r_cur     <= '0;
            r_aborted <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_cnt     <= w_cnt;
            r_mask    <= w_mask;
            r_sel     <= w_sel;
            r_pass    <= w_pass;
            r_fail    <= w_fail;
            r_cur     <= w_cur;
            r_aborted <= w_aborted;
        end
    end
endmodule

// File: doc/axi_adc_jesd204_pn_seq.md
AXI_ADC_JESD204_PN_SEQ -- requirements
Module: axi_adc_jesd204_pn_seq

Interface
REQ-001 SHALL have parameter NUM_CHANNELS, default 4: number of ADC channels sequenced (1..16).
REQ-002 SHALL have parameter SETTLE_CYCLES, default 1024: cycles waited after PN select change before checking (>=1).
REQ-003 SHALL have parameter CHECK_CYCLES, default 4096: length of PN check window in cycles (>=1).
REQ-004 SHALL use one clock and an asynchronous active-low reset: up_clk and up_rstn.
REQ-005 up_clk  input  1  processor-domain clock; all logic on rising edge.
REQ-006 up_rstn  input  1  asynchronous active-low reset.
REQ-007 start  input  1  single-cycle request to begin a sweep; honoured only in IDLE.
REQ-008 abort  input  1  terminates a running sweep.
REQ-009 channel_mask  input  NUM_CHANNELS  bit i=1: channel i is tested; sampled at start.
REQ-010 test_pnseq_sel  input  4  PN select applied to the channel under test; sampled at start.
REQ-011 idle_pnseq_sel  input  4  PN select held by every channel not under test.
REQ-012 up_adc_pn_oos  input  NUM_CHANNELS  per-channel PN out-of-sync status.
REQ-013 up_adc_pn_err  input  NUM_CHANNELS  per-channel PN error status.
REQ-014 up_adc_pnseq_sel  output  4*NUM_CHANNELS  per-channel PN select, channel i at bits [4i+3:4i].
REQ-015 busy  output  1  sweep in progress.
REQ-016 done  output  1  one-cycle pulse on successful sweep completion.
REQ-017 aborted  output  1  one-cycle pulse when a sweep is aborted.
REQ-018 pass  output  NUM_CHANNELS  per-channel result; bit i=1: channel i tested and clean.
REQ-019 cur_channel  output  4  index of channel under test; 0 when idle.

Function
REQ-020 States SHALL be IDLE, SETTLE, CHECK, DONE; counter width SHALL be clog2(max(SETTLE_CYCLES,CHECK_CYCLES))+1.
REQ-021 IDLE with start=1 and mask!=0: next edge SHALL latch mask and test_pnseq_sel, clear pass, set busy=1, select lowest enabled channel, drive its select to latched value, enter SETTLE.
REQ-022 IDLE with start=1 and mask=0: SHALL enter DONE directly; pass=0; busy stays 0.
REQ-023 start while busy SHALL be ignored; channel_mask/test_pnseq_sel changes after start SHALL have no effect on the running sweep.
REQ-024 SETTLE SHALL last exactly SETTLE_CYCLES cycles, status ignored, then enter CHECK with fail flag cleared.
REQ-025 CHECK SHALL last exactly CHECK_CYCLES cycles; fail flag SHALL become sticky 1 on any cycle where pn_oos or pn_err of cur_channel is 1.
REQ-026 At CHECK end: pass[cur]=~fail (including the last window cycle); that channel's select SHALL return to idle_pnseq_sel on the same edge; next enabled channel (ascending) SHALL enter SETTLE on the same edge with no gap cycle.
REQ-027 After the last enabled channel: enter DONE; DONE SHALL last one cycle with done=1, busy=0, then IDLE.
REQ-028 Per-channel latency SHALL be SETTLE_CYCLES+CHECK_CYCLES cycles; sweep = that times popcount(mask), plus 1 DONE cycle.
REQ-029 Only the channel under test SHALL ever drive a select other than idle_pnseq_sel; idle_pnseq_sel SHALL pass through combinationally to non-tested channels.
REQ-030 abort in SETTLE/CHECK SHALL on next edge restore all selects to idle, set busy=0, pulse aborted for one cycle, enter IDLE, keep pass bits of already-finished channels, leave untested bits 0; done SHALL NOT pulse.
REQ-031 abort and start in same IDLE cycle: start SHALL win; abort in IDLE or DONE SHALL be ignored.
REQ-032 abort coinciding with final CHECK cycle SHALL take priority: result of that channel SHALL NOT be written.

Reset
REQ-033 up_rstn low SHALL asynchronously force IDLE, busy=0, done=0, aborted=0, pass=0, cur_channel=0, counters 0, all selects = idle_pnseq_sel.
REQ-034 Reset deassertion mid-sweep SHALL NOT resume; a new start is required.

Verification (NUM_CHANNELS=4, SETTLE_CYCLES=8, CHECK_CYCLES=16)
REQ-035 mask=4'b1111, sel=4'h5, status all 0 -> channels 0..3 each see sel 5 for 24 cycles in turn; done pulses 97 cycles after start edge; pass=4'b1111.
REQ-036 mask=4'b1010, pn_err[3]=1 for one cycle mid-CHECK of ch3 -> only ch1, ch3 tested; pass=4'b0010; pn_oos[3] during ch3 SETTLE alone -> pass=4'b1010.
REQ-037 mask=4'b1111, abort during ch2 CHECK -> next edge busy=0, aborted pulse, all selects idle, pass=4'b0011, no done.
REQ-038 start with mask=0 -> done pulse one cycle after start edge, busy never 1, pass=0; start repeated while busy -> no restart, timing unchanged.
REQ-039 up_rstn asserted during ch1 SETTLE -> immediate IDLE and idle selects; after release, outputs stay idle until next start.
